// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage: op encoding,
// default datapath width, flag bit positions and pipeline register states.
package alu_pkg;

    localparam int unsigned WIDTH_DEFAULT = 64;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [2:0] {
        OP_PASSB = 3'b000,
        OP_RSV1  = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110,
        OP_RSV7  = 3'b111
    } alu_op_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Reserved encodings produce a zero result and never touch the flags.
    function automatic logic isDefinedOp(input alu_op_t op);
        return (op != OP_RSV1) && (op != OP_RSV7);
    endfunction

endpackage

// File: rtl/alu_result_stage_flag_calc.sv
// Combinational {N,Z,C,V} computation from the selected ALU result.
module flag_calc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] result,
    input  logic [2:0]       op,
    input  logic             aMsb,
    input  logic             bMsb,
    input  logic             coutAdd,
    input  logic             coutSub,
    output logic [3:0]       flags
);

    logic resMsb;

    always_comb begin
        resMsb = result[WIDTH-1];
        flags = '0;
        flags[FLAG_N] = resMsb;
        flags[FLAG_Z] = (result == '0);
        case (alu_op_t'(op))
            OP_ADD: begin
                flags[FLAG_C] = coutAdd;
                flags[FLAG_V] = (aMsb == bMsb) && (resMsb != aMsb);
            end
            OP_SUB: begin
                flags[FLAG_C] = coutSub;
                flags[FLAG_V] = (aMsb != bMsb) && (resMsb != aMsb);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// One-entry registered result stage: selects the ALU result, computes flags,
// and holds them behind a valid/ready handshake with full throughput.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] diff_in,
    input  logic             cout_add,
    input  logic             cout_sub,
    input  logic [WIDTH-1:0] and_in,
    input  logic [WIDTH-1:0] or_in,
    input  logic [WIDTH-1:0] xor_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             set_flags,
    input  logic [4:0]       dest_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       dest_out,
    output logic             zero,
    output logic [3:0]       flags
);

    state_t           state;
    state_t           stateNext;
    logic             outValid;
    logic             inReady;
    logic             loadEn;
    logic             unloadEn;
    logic             flagEn;
    alu_op_t          op;
    logic [WIDTH-1:0] selResult;
    logic [3:0]       calcFlags;

    logic [WIDTH-1:0] resultReg;
    logic [4:0]       destReg;
    logic             zeroReg;
    logic [3:0]       flagsReg;

    always_comb begin
        op = alu_op_t'(alu_op);
        selResult = '0;
        case (op)
            OP_PASSB: selResult = b_in;
            OP_ADD:   selResult = sum_in;
            OP_SUB:   selResult = diff_in;
            OP_AND:   selResult = and_in;
            OP_OR:    selResult = or_in;
            OP_XOR:   selResult = xor_in;
            default:  selResult = '0;
        endcase
    end

    flag_calc #(.WIDTH(WIDTH)) uFlagCalc (
        .result  (selResult),
        .op      (alu_op),
        .aMsb    (a_msb),
        .bMsb    (b_msb),
        .coutAdd (cout_add),
        .coutSub (cout_sub),
        .flags   (calcFlags)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Ready looks through a full register when downstream drains it this cycle.
    always_comb begin
        stateNext = state;
        outValid  = (state == ST_FULL);
        inReady   = !outValid || out_ready;
        loadEn    = in_valid && inReady;
        unloadEn  = outValid && out_ready;
        flagEn    = loadEn && set_flags && isDefinedOp(op);
        case (state)
            ST_EMPTY: if (loadEn) stateNext = ST_FULL;
            ST_FULL:  if (unloadEn && !loadEn) stateNext = ST_EMPTY;
            default:  stateNext = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resultReg <= '0;
            destReg   <= '0;
            zeroReg   <= 1'b0;
            flagsReg  <= '0;
        end else begin
            if (loadEn) begin
                resultReg <= selResult;
                destReg   <= dest_in;
                zeroReg   <= (selResult == '0);
            end
            if (flagEn) begin
                flagsReg <= calcFlags;
            end
        end
    end

    assign in_ready  = inReady;
    assign out_valid = outValid;
    assign result    = resultReg;
    assign dest_out  = destReg;
    assign zero      = zeroReg;
    assign flags     = flagsReg;

endmodule

// File: tb/tb_alu_result_stage.sv
// Table-driven, scoreboarded bench for alu_result_stage (WIDTH=64).
module tb_alu_result_stage;

    typedef struct {
        logic [2:0]  op;
        logic        aMsb;
        logic        bMsb;
        logic [63:0] sel;
        logic        cAdd;
        logic        cSub;
        logic        setF;
        logic [4:0]  dest;
        logic [63:0] expRes;
        logic [3:0]  expFlags;
        logic        expZero;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  dest;
        logic        zero;
        logic [3:0]  flags;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alu_op = '0;
    logic        a_msb = 1'b0;
    logic        b_msb = 1'b0;
    logic [63:0] sum_in = '0;
    logic [63:0] diff_in = '0;
    logic        cout_add = 1'b0;
    logic        cout_sub = 1'b0;
    logic [63:0] and_in = '0;
    logic [63:0] or_in = '0;
    logic [63:0] xor_in = '0;
    logic [63:0] b_in = '0;
    logic        set_flags = 1'b0;
    logic [4:0]  dest_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic [4:0]  dest_out;
    logic        zero;
    logic [3:0]  flags;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cycle = 0;
    sb_t         sbq[$];
    vec_t        vecs[11];

    alu_result_stage #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .a_msb(a_msb), .b_msb(b_msb),
        .sum_in(sum_in), .diff_in(diff_in), .cout_add(cout_add), .cout_sub(cout_sub),
        .and_in(and_in), .or_in(or_in), .xor_in(xor_in), .b_in(b_in),
        .set_flags(set_flags), .dest_in(dest_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .dest_out(dest_out), .zero(zero), .flags(flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic am, input logic bm,
                                input logic [63:0] sel, input logic ca, input logic cs,
                                input logic sf, input logic [4:0] d, input logic [63:0] er,
                                input logic [3:0] ef, input logic ez);
        vec_t v;
        v.op = op; v.aMsb = am; v.bMsb = bm; v.sel = sel; v.cAdd = ca; v.cSub = cs;
        v.setF = sf; v.dest = d; v.expRes = er; v.expFlags = ef; v.expZero = ez;
        return v;
    endfunction

    // Distinct background values on every path so a wrong select shows up.
    task automatic applyVec(input vec_t v);
        alu_op = v.op; a_msb = v.aMsb; b_msb = v.bMsb;
        cout_add = v.cAdd; cout_sub = v.cSub; set_flags = v.setF; dest_in = v.dest;
        sum_in  = 64'h1111_1111_1111_1111;
        diff_in = 64'h2222_2222_2222_2222;
        and_in  = 64'h3333_3333_3333_3333;
        or_in   = 64'h4444_4444_4444_4444;
        xor_in  = 64'h5555_5555_5555_5555;
        b_in    = 64'h6666_6666_6666_6666;
        case (v.op)
            3'b000: b_in = v.sel;
            3'b010: sum_in = v.sel;
            3'b011: diff_in = v.sel;
            3'b100: and_in = v.sel;
            3'b101: or_in = v.sel;
            3'b110: xor_in = v.sel;
            default: ;
        endcase
        in_valid = 1'b1;
    endtask

    task automatic pushExp(input vec_t v);
        sb_t e;
        e.res = v.expRes; e.dest = v.dest; e.zero = v.expZero; e.flags = v.expFlags;
        sbq.push_back(e);
    endtask

    // Drive a vector and hold it until accepted; returns just after the accepting edge.
    task automatic send(input vec_t v);
        bit done = 0;
        applyVec(v);
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                pushExp(v);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL send_timeout: got no in_ready expected accept within 20 cycles");
        end
    endtask

    // Scoreboard: pop and compare on every output transfer.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb_unexpected: got result %h expected no output", result);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_dest", 64'(dest_out), 64'(e.dest));
                chk("sb_zero", 64'(zero), 64'(e.zero));
                chk("sb_flags", 64'(flags), 64'(e.flags));
            end
        end
    end

    initial begin
        sb_t         e;
        logic [63:0] holdRes;
        int unsigned c0;
        vec_t        v;
        vec_t        w;

        vecs[0]  = mk(3'b010, 0, 0, 64'h8000_0000_0000_0000, 0, 0, 1, 5'd1,  64'h8000_0000_0000_0000, 4'b1001, 0);
        vecs[1]  = mk(3'b011, 1, 1, 64'h0,                   0, 1, 1, 5'd2,  64'h0,                   4'b0110, 1);
        vecs[2]  = mk(3'b100, 0, 0, 64'h0000_0000_0000_00FF, 0, 0, 0, 5'd3,  64'h0000_0000_0000_00FF, 4'b0110, 0);
        vecs[3]  = mk(3'b111, 0, 0, 64'h0,                   1, 1, 1, 5'd4,  64'h0,                   4'b0110, 1);
        vecs[4]  = mk(3'b001, 1, 0, 64'h0,                   1, 1, 1, 5'd5,  64'h0,                   4'b0110, 1);
        vecs[5]  = mk(3'b110, 0, 0, 64'h0000_F0F0_0000_F0F0, 1, 1, 1, 5'd6,  64'h0000_F0F0_0000_F0F0, 4'b0000, 0);
        vecs[6]  = mk(3'b101, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 5'd7,  64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 0);
        vecs[7]  = mk(3'b000, 0, 0, 64'h0,                   1, 1, 1, 5'd8,  64'h0,                   4'b0100, 1);
        vecs[8]  = mk(3'b010, 1, 1, 64'h0000_0000_0000_0005, 1, 0, 1, 5'd9,  64'h0000_0000_0000_0005, 4'b0011, 0);
        vecs[9]  = mk(3'b011, 0, 1, 64'h8000_0000_0000_0001, 0, 0, 1, 5'd10, 64'h8000_0000_0000_0001, 4'b1001, 0);
        vecs[10] = mk(3'b010, 0, 1, 64'h0,                   1, 0, 1, 5'd11, 64'h0,                   4'b0110, 1);

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_flags", 64'(flags), 64'd0);
        chk("reset_zero", 64'(zero), 64'd0);
        chk("reset_dest", 64'(dest_out), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // No load while empty without in_valid.
        b_in = 64'hDEAD_BEEF; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_no_load", result, 64'd0);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) send(vecs[i]);
        in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Stall while full: in_ready low, register stable, then reload on release.
        out_ready = 1'b0;
        v = mk(3'b100, 0, 0, 64'h0000_0000_1234_5678, 0, 0, 1, 5'd20, 64'h0000_0000_1234_5678, 4'b0000, 0);
        send(v);
        holdRes = 64'h0000_0000_1234_5678;
        w = mk(3'b010, 1, 1, 64'h7000_0000_0000_0000, 1, 0, 1, 5'd21, 64'h7000_0000_0000_0000, 4'b0011, 0);
        applyVec(w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_result", result, holdRes);
            chk("stall_dest", 64'(dest_out), 64'd20);
            chk("stall_flags", 64'(flags), 64'b0000);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        pushExp(w);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("reload_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // Back-to-back: one result per cycle, flags left as they were.
        c0 = cycle;
        for (int i = 0; i < 8; i++) begin
            logic [63:0] bv;
            bv = 64'h0100_0000_0000_0000 * 64'(i + 1) + 64'(i);
            v = mk(3'b000, 0, 0, bv, 0, 0, 0, 5'(i + 12), bv, 4'b0011, 0);
            send(v);
        end
        chk("b2b_cycles", 64'(cycle - c0), 64'd8);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("b2b_drained", 64'(sbq.size()), 64'd0);
        chk("b2b_empty", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Reset while full with an incoming transfer.
        out_ready = 1'b0;
        send(vecs[0]);
        applyVec(vecs[6]);
        reset = 1'b1;
        @(negedge clk);
        sbq.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_result", result, 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_no_output", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
